// File: rtl/unit_input_pkt.sv
// unit_input_pkt: narrow-bus packets buffered in a FIFO, assembled into 32-bit words for the selected thread's memory; UNIT_INPUT_LEN_CHECK_EN enables length checking.
// Latency: a sub-word pops 1 cycle after it is written; a word shows empty=0 1 cycle after its last pop; thread search samples ts_rd TS_LATENCY cycles after ts_num moves.
// Backpressure: afull from registered FIFO fill during LOAD, writes into a full FIFO are dropped; ready stays low until an idle thread is found.
module unit_input_pkt #(
  parameter int N_THREADS   = 16,
  parameter int INPUT_WIDTH = 8,
  parameter int RATIO       = 32 / INPUT_WIDTH,
  parameter int BUF_DEPTH   = 32,
  parameter int AFULL_SIZE  = 13,
  parameter int MEM_ADDR_W  = 6,
  parameter int TS_W        = 2,
  parameter int TS_NONE     = 0,
  parameter int TS_WR_RDY   = 1,
  parameter int TS_LATENCY  = 4,
  parameter int ENTRY_PT_W  = 3,
  localparam int TN_W = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [INPUT_WIDTH-1:0]     in,
  input  logic                       ctrl,
  input  logic                       wr_en,
  output logic                       afull,
  output logic                       ready,
  output logic [31:0]                out,
  output logic [TN_W+MEM_ADDR_W-1:0] mem_addr,
  input  logic                       rd_en,
  output logic                       empty,
  output logic [TN_W-1:0]            ts_num,
  output logic                       ts_wr_en,
  output logic [TS_W-1:0]            ts_wr,
  input  logic [TS_W-1:0]            ts_rd,
  output logic [ENTRY_PT_W-1:0]      entry_pt_curr,
  output logic                       pkt_err
);

  localparam int BW = $clog2(BUF_DEPTH);
  localparam int KW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int LW = 4;
  localparam logic [BW:0]       DEPTH_C   = (BW+1)'(BUF_DEPTH);
  localparam logic [BW:0]       AFULL_C   = (BW+1)'(BUF_DEPTH - AFULL_SIZE);
  localparam logic [KW-1:0]     K_LAST    = KW'(RATIO - 1);
  localparam logic [LW-1:0]     LAT_C     = LW'(TS_LATENCY);
  localparam logic [TS_W-1:0]   TS_NONE_C = TS_W'(TS_NONE);
  localparam logic [TN_W-1:0]   TN_LAST   = TN_W'(N_THREADS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SKIP, S_LOAD, S_DRAIN, S_SRCH_INC, S_SRCH_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [BW:0]            wr_ptr, rd_ptr, fill;
  logic                   fifo_empty, fifo_full, push, pop;
  logic [INPUT_WIDTH-1:0] fifo_rd;
  logic [KW-1:0]          sub_k;
  logic [MEM_ADDR_W-1:0]  waddr;
  logic [LW-1:0]          lat_cnt;
  logic hdr_data, hdr_ep, drain_done, pad, len_err, thr_free;

  // Extra pointer bit distinguishes full from empty.
  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (fill == '0);
  assign fifo_full  = (fill == DEPTH_C);
  assign push       = (state_q == S_LOAD) && wr_en && !fifo_full;
  assign pop        = !fifo_empty && empty;
  assign fifo_rd    = buf_mem[rd_ptr[BW-1:0]];
  assign mem_addr   = {ts_num, waddr};
  assign ts_wr      = TS_W'(TS_WR_RDY);

  always_ff @(posedge CLK) begin
    if (push) buf_mem[wr_ptr[BW-1:0]] <= in;
  end

  always_comb begin
    state_d    = state_q;
    hdr_data   = 1'b0;
    hdr_ep     = 1'b0;
    drain_done = 1'b0;
    pad        = 1'b0;
    len_err    = 1'b0;
    thr_free   = 1'b0;
    case (state_q)
      S_IDLE: if (wr_en && ctrl) begin
        if (in[2:0] == 3'd0) begin
          hdr_data = 1'b1;
          state_d  = S_LOAD;
        end else begin
          hdr_ep  = (in[2:0] == 3'd1);
          state_d = S_SKIP;
        end
      end
      S_SKIP: if (wr_en && ctrl) state_d = S_IDLE;
      S_LOAD: if (wr_en && ctrl) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty && empty) begin
        if (sub_k == '0) begin
          drain_done = 1'b1;
          state_d    = S_SRCH_INC;
        end else begin
`ifdef UNIT_INPUT_LEN_CHECK_EN
          len_err = 1'b1;
          state_d = S_IDLE;
`else
          pad = 1'b1;
`endif
        end
      end
      S_SRCH_INC: state_d = S_SRCH_WAIT;
      S_SRCH_WAIT: if (lat_cnt == LAT_C) begin
        if (ts_rd == TS_NONE_C) begin
          thr_free = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d = S_SRCH_INC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      sub_k         <= '0;
      out           <= '0;
      empty         <= 1'b1;
      waddr         <= '0;
      ts_num        <= '0;
      ts_wr_en      <= 1'b0;
      lat_cnt       <= '0;
      ready         <= 1'b1;
      afull         <= 1'b0;
      entry_pt_curr <= '0;
    end else begin
      state_q  <= state_d;
      ts_wr_en <= drain_done;
      afull    <= (state_q == S_LOAD) && (fill >= AFULL_C);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // Sub-word 0 clears the word so a short residual comes out zero-padded.
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (sub_k == '0) out <= 32'(fifo_rd);
        else             out[int'(sub_k)*INPUT_WIDTH +: INPUT_WIDTH] <= fifo_rd;
        if (sub_k == K_LAST) begin
          sub_k <= '0;
          empty <= 1'b0;
        end else begin
          sub_k <= sub_k + 1'b1;
        end
      end else if (pad) begin
        sub_k <= '0;
        empty <= 1'b0;
      end else if (len_err) begin
        sub_k <= '0;
      end else if (rd_en && !empty) begin
        empty <= 1'b1;
      end
      if (hdr_data)               waddr <= '0;
      else if (rd_en && !empty)   waddr <= waddr + 1'b1;
      if (hdr_data)               ready <= 1'b0;
      else if (thr_free || len_err) ready <= 1'b1;
      if (hdr_ep) entry_pt_curr <= in[ENTRY_PT_W+2:3];
      if (state_q == S_SRCH_INC) begin
        ts_num  <= (ts_num == TN_LAST) ? '0 : ts_num + 1'b1;
        lat_cnt <= '0;
      end else if (state_q == S_SRCH_WAIT && lat_cnt != LAT_C) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
    end
  end

`ifdef UNIT_INPUT_LEN_CHECK_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)       pkt_err <= 1'b0;
    else if (len_err) pkt_err <= 1'b1;
  end
`else
  assign pkt_err = 1'b0;
`endif

endmodule

// File: tb/tb_unit_input_pkt.sv
// Bench for unit_input_pkt (default parameters): packets built from byte queues, expected
// memory words, thread selection and error flag derived from packet rules, not from RTL state.
module tb_unit_input_pkt;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  in_d;
  logic        ctrl, wr_en, rd_en;
  logic        afull, ready, empty, ts_wr_en, pkt_err;
  logic [31:0] out_w;
  logic [9:0]  mem_addr;
  logic [3:0]  ts_num;
  logic [1:0]  ts_wr, ts_rd;
  logic [2:0]  entry_pt;

  int n_chk = 0;
  int n_err = 0;

  unit_input_pkt dut (
    .CLK(CLK), .RST_N(RST_N), .in(in_d), .ctrl(ctrl), .wr_en(wr_en),
    .afull(afull), .ready(ready), .out(out_w), .mem_addr(mem_addr),
    .rd_en(rd_en), .empty(empty), .ts_num(ts_num), .ts_wr_en(ts_wr_en),
    .ts_wr(ts_wr), .ts_rd(ts_rd), .entry_pt_curr(entry_pt), .pkt_err(pkt_err)
  );

  always #5 CLK = ~CLK;

  // Thread-state memory with a 4-cycle read pipeline (TS_LATENCY).
  logic [1:0] ts_state [16];
  logic [1:0] rd_pipe [4];
  assign ts_rd = rd_pipe[3];
  always @(posedge CLK) begin
    rd_pipe[0] <= ts_state[ts_num];
    for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Memory-side observer.
  logic [41:0] got_q[$];
  int          pulse_cnt = 0;
  int          long_pulse = 0;
  logic [3:0]  pulse_thr = '0;
  logic        prev_wr = 1'b0;
  initial forever begin
    @(negedge CLK);
    if (RST_N) begin
      if (rd_en && !empty) got_q.push_back({mem_addr, out_w});
      if (ts_wr_en) begin
        pulse_cnt++;
        pulse_thr = ts_num;
        if (prev_wr) long_pulse++;
      end
      prev_wr = ts_wr_en;
    end
  end

  int rd_mode = 2;  // 0: hold low, 1: hold high, 2: random
  initial begin
    rd_en = 1'b0;
    forever begin
      @(posedge CLK); #1;
      rd_en = (rd_mode == 1) || (rd_mode == 2 && $urandom_range(0, 2) != 0);
    end
  end

  logic [7:0]  pkt_q[$];
  logic [41:0] exp_q[$];
  int cur_thr = 0, wr_thr = 0, exp_pulses = 0, got_rd = 0, gap_pct = 0;
  bit exp_err = 1'b0, exp_write = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 2000 && ready !== 1'b1; c++) tick();
    chk("ready_wait", 64'(ready), 64'(1));
  endtask

  // Packet rules: little-endian bytes per word, residual padded or rejected,
  // then next idle thread after the written one, wrapping at 16.
  task automatic predict_pkt();
    int n, nw, rem;
    logic [31:0] w;
    n   = pkt_q.size();
    nw  = n / 4;
    rem = n % 4;
    exp_q.delete();
`ifdef UNIT_INPUT_LEN_CHECK_EN
    exp_write = (rem == 0);
`else
    exp_write = 1'b1;
    if (rem != 0) nw++;
`endif
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int b = 0; b < 4; b++)
        if (4*k + b < n) w |= 32'(pkt_q[4*k + b]) << (8*b);
      exp_q.push_back({4'(cur_thr), 6'(k), w});
    end
    if (!exp_write) begin
      exp_err = 1'b1;
    end else begin
      exp_pulses++;
      wr_thr = cur_thr;
      for (int s = 15; s >= 1; s--)
        if (ts_state[(wr_thr + s) % 16] == 2'd0) cur_thr = (wr_thr + s) % 16;
    end
  endtask

  task automatic send_hdr(input logic [7:0] h);
    wait_ready();
    in_d = h; ctrl = 1'b1; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; ctrl = 1'b0;
  endtask

  task automatic send_bytes(input int from, input int to, input bit last);
    for (int i = from; i < to; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin wr_en = 1'b0; tick(); end
      in_d = pkt_q[i]; ctrl = last && (i == to - 1); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0; ctrl = 1'b0;
  endtask

  task automatic finish_pkt();
    wait_ready();
    chk("word_count", 64'(got_q.size() - got_rd), 64'(exp_q.size()));
    foreach (exp_q[k]) begin
      if (got_rd < got_q.size()) begin
        chk($sformatf("word%0d", k), 64'(got_q[got_rd]), 64'(exp_q[k]));
        got_rd++;
      end
    end
    got_rd = got_q.size();
    chk("ts_wr_pulses", 64'(pulse_cnt), 64'(exp_pulses));
    chk("ts_wr_pulse_len", 64'(long_pulse), 64'(0));
    chk("ts_num", 64'(ts_num), 64'(cur_thr));
    chk("pkt_err", 64'(pkt_err), 64'(exp_err));
    if (exp_write) begin
      chk("pulse_thread", 64'(pulse_thr), 64'(wr_thr));
      ts_state[wr_thr] = 2'd1;
    end
  endtask

  task automatic data_pkt(input int n, input bit fixed);
    pkt_q.delete();
    for (int i = 0; i < n; i++) pkt_q.push_back(fixed ? 8'(i + 1) : 8'($urandom));
    predict_pkt();
    send_hdr(8'h00);
    chk("hdr_ready_low", 64'(ready), 64'(0));
    send_bytes(0, n, 1'b1);
    finish_pkt();
  endtask

  initial begin
    RST_N = 1'b0; in_d = '0; ctrl = 1'b0; wr_en = 1'b0;
    for (int t = 0; t < 16; t++) ts_state[t] = 2'd0;
    repeat (3) tick();
    chk("rst_afull", 64'(afull), 64'(0));
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_out", 64'(out_w), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_ts_num", 64'(ts_num), 64'(0));
    chk("rst_ts_wr_en", 64'(ts_wr_en), 64'(0));
    chk("rst_entry", 64'(entry_pt), 64'(0));
    chk("rst_pkt_err", 64'(pkt_err), 64'(0));
    chk("ts_wr_const", 64'(ts_wr), 64'(1));
    RST_N = 1'b1;
    tick();

    // Eight bytes 01..08 into thread 0.
    data_pkt(8, 1'b1);
    chk("p1_word1", 64'(got_q[1]), 64'({4'd0, 6'd1, 32'h08070605}));

    // Entry-point packet: type 1, entry 5; then an unknown type leaves it alone.
    send_hdr(8'h29);
    chk("ep_ready", 64'(ready), 64'(1));
    in_d = 8'hff; wr_en = 1'b1; tick();
    ctrl = 1'b1; tick();
    wr_en = 1'b0; ctrl = 1'b0; tick();
    chk("ep_value", 64'(entry_pt), 64'(5));
    send_hdr(8'h12);
    in_d = 8'h00; ctrl = 1'b1; wr_en = 1'b1; tick();
    wr_en = 1'b0; ctrl = 1'b0; repeat (2) tick();
    chk("ep_other_type", 64'(entry_pt), 64'(5));
    chk("ep_no_write", 64'(got_q.size()), 64'(got_rd));
    chk("ep_no_pulse", 64'(pulse_cnt), 64'(exp_pulses));

    // Busy threads force the search to step over them, then wrap 15 -> 0.
    gap_pct = 30;
    ts_state[2] = 2'd2; ts_state[3] = 2'd2;
    data_pkt(4 * $urandom_range(1, 8), 1'b0);
    for (int t = 5; t < 15; t++) ts_state[t] = 2'd2;
    data_pkt(4 * $urandom_range(1, 8), 1'b0);
    ts_state[0] = 2'd0;
    data_pkt(4 * $urandom_range(1, 8), 1'b0);
    chk("wrap_to_0", 64'(ts_num), 64'(0));
    for (int t = 0; t < 16; t++) ts_state[t] = 2'd0;

    // Memory stalled: afull threshold at fill 19, nothing lost on release.
    gap_pct = 0;
    rd_mode = 0;
    pkt_q.delete();
    for (int i = 0; i < 25; i++) pkt_q.push_back(8'($urandom));
    predict_pkt();
    send_hdr(8'h00);
    send_bytes(0, 22, 1'b0);
    repeat (2) tick();
    chk("afull_fill18", 64'(afull), 64'(0));
    chk("held_word", 64'(empty), 64'(0));
    send_bytes(22, 23, 1'b0);
    repeat (2) tick();
    chk("afull_fill19", 64'(afull), 64'(1));
    send_bytes(23, 25, 1'b1);
    rd_mode = 2;
    finish_pkt();

    // Five-byte packet: residual handling.
    rd_mode = 1;
    data_pkt(5, 1'b1);
`ifndef UNIT_INPUT_LEN_CHECK_EN
    chk("five_byte_tail", 64'(got_q[got_rd - 1]), 64'({4'(wr_thr), 6'd1, 32'h00000005}));
`endif
    rd_mode = 2;
    gap_pct = 20;
    for (int p = 0; p < 2; p++) data_pkt(4 * $urandom_range(1, 5), 1'b0);
    data_pkt($urandom_range(1, 20), 1'b0);

    // Reset in the middle of a load.
    pkt_q.delete();
    for (int i = 0; i < 3; i++) pkt_q.push_back(8'($urandom));
    send_hdr(8'h00);
    send_bytes(0, 3, 1'b0);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_empty", 64'(empty), 64'(1));
    chk("mid_rst_ready", 64'(ready), 64'(1));
    chk("mid_rst_ts_num", 64'(ts_num), 64'(0));
    chk("mid_rst_afull", 64'(afull), 64'(0));
    tick();
    RST_N = 1'b1;
    cur_thr = 0;
    exp_err = 1'b0;
    for (int t = 0; t < 16; t++) ts_state[t] = 2'd0;
    got_rd = got_q.size();
    repeat (5) tick();
    data_pkt(8, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
